reset_sequencer: RTL and testbench

- Parametrised successor to the single-output power-on reset generator.
- Produces NUM_CH active-high reset outputs:
  - All outputs are held for HOLD_CYCLES.
  - They are then released one at a time, STAGE_GAP cycles apart.
- Asserts done when the last channel is released.
- Sits at the top of the SoC and drives staged resets (for example clocking, then bus, then CPU, then peripherals).
- Supports external restart (rst) and a software restart request (soft_req).

---
 rtl/reset_sequencer_pkg.sv | 13 +
 rtl/reset_sequencer_timer.sv | 21 ++
 rtl/reset_sequencer.sv | 108 ++++++++++
 tb/tb_reset_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared state encoding and default timing constants for the reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGE_GAP   = 8;

endpackage

// File: rtl/reset_sequencer_timer.sv
// reset_seq_timer: CNT_W up-counter with sync clear, enable and terminal-count compare.
module reset_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

    assign hit = cnt == tc;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds NUM_CH resets, then releases them one by one STAGE_GAP apart.
// Optional RST_SEQ_LOCK_EN adds a lock input that gates the hold phase and restarts on lock loss.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_req,
`ifdef RST_SEQ_LOCK_EN
    input  logic              lock,
`endif
    output logic [NUM_CH-1:0] rst_out,
    output logic              done
);

    localparam int CH_W = $clog2(NUM_CH + 1);

    // Every register resets to zero, so an all-zero FPGA power-up image is the reset state.
    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [NUM_CH-1:0]  rel_q, rel_d;
    logic               done_q, done_d;
    logic               clr, en, hit, restart, hold_ok, lock_drop;
    logic [CNT_W-1:0]   tc;

`ifdef RST_SEQ_LOCK_EN
    assign hold_ok   = lock;
    assign lock_drop = !lock && state_q != HOLD;
`else
    assign hold_ok   = 1'b1;
    assign lock_drop = 1'b0;
`endif

    assign restart = rst || soft_req || lock_drop;
    assign tc      = state_q == HOLD ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(STAGE_GAP - 1);

    reset_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk (clk),
        .clr (clr),
        .en  (en),
        .tc  (tc),
        .hit (hit)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rel_d   = rel_q;
        done_d  = done_q;
        clr     = 1'b0;
        en      = 1'b0;
        case (state_q)
            HOLD: begin
                en = hold_ok;
                if (hit && hold_ok) begin
                    rel_d   = rel_q | NUM_CH'(1);
                    ch_d    = CH_W'(1);
                    clr     = 1'b1;
                    state_d = NUM_CH == 1 ? DONE : RELEASE;
                    done_d  = NUM_CH == 1;
                end
            end
            RELEASE: begin
                en = 1'b1;
                if (hit) begin
                    rel_d = rel_q | (NUM_CH'(1) << ch_q);
                    ch_d  = ch_q + 1'b1;
                    clr   = 1'b1;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (restart) begin
            state_d = HOLD;
            ch_d    = '0;
            rel_d   = '0;
            done_d  = 1'b0;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD;
            ch_q    <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    assign rst_out = ~rel_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for a 4-channel default instance and a 1-channel, 3-cycle instance.
module tb_reset_sequencer;

`ifdef RST_SEQ_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] r4;
        logic       d4;
        logic       r1;
        logic       d1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       soft_req = 1'b0;
    logic       lock = 1'b1;
    logic [3:0] rst_out4;
    logic       done4;
    logic [0:0] rst_out1;
    logic       done1;

    int   errors = 0;
    int   checks = 0;
    int   p4 = 0;
    int   p1 = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    reset_sequencer dut4 (
        .clk      (clk),
        .rst      (rst),
        .soft_req (soft_req),
`ifdef RST_SEQ_LOCK_EN
        .lock     (lock),
`endif
        .rst_out  (rst_out4),
        .done     (done4)
    );

    reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(3)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .soft_req (soft_req),
`ifdef RST_SEQ_LOCK_EN
        .lock     (lock),
`endif
        .rst_out  (rst_out1),
        .done     (done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // p counts effective sequencing edges since the last restart.
    function automatic int nxt(input int p, input int h, input bit r, input bit s, input bit lk);
        if (r || s) return 0;
        if (LOCK_EN && !lk) return p >= h ? 0 : p;
        return p < 10000 ? p + 1 : p;
    endfunction

    function automatic exp_t expect_of(input int a, input int b);
        exp_t e;
        for (int c = 0; c < 4; c++) e.r4[c] = a < 16 + c * 8;
        e.d4 = a >= 40;
        e.r1 = b < 3;
        e.d1 = b >= 3;
        return e;
    endfunction

    task automatic step(input bit r, input bit s, input bit lk);
        exp_t e;
        rst      = r;
        soft_req = s;
        lock     = lk;
        p4 = nxt(p4, 16, r, s, lk);
        p1 = nxt(p1, 3, r, s, lk);
        q.push_back(expect_of(p4, p1));
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("rst_out4", 32'(rst_out4), 32'(e.r4));
        check("done4", 32'(done4), 32'(e.d4));
        check("rst_out1", 32'(rst_out1), 32'(e.r1));
        check("done1", 32'(done1), 32'(e.d1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #1;
        check("pwrup_rst_out4", 32'(rst_out4), 32'hF);
        check("pwrup_done4", 32'(done4), 32'h0);
        check("pwrup_rst_out1", 32'(rst_out1), 32'h1);
        check("pwrup_done1", 32'(done1), 32'h0);
        run(45);
        step(1'b1, 1'b0, 1'b1);
        run(27);
        step(1'b0, 1'b1, 1'b1);
        run(45);
        step(1'b1, 1'b0, 1'b1);
        run(49);
        step(1'b1, 1'b1, 1'b1);
        run(45);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        run(20);
        step(1'b0, 1'b1, 1'b1);
        run(5);
        step(1'b0, 1'b1, 1'b1);
        run(44);
        if (LOCK_EN) begin
            step(1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
            run(45);
            step(1'b0, 1'b0, 1'b0);
            run(20);
            step(1'b0, 1'b0, 1'b0);
            run(45);
        end
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0,
                 !LOCK_EN || $urandom_range(0, 29) != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
